// File: rtl/mem_access_stage_pkg.sv
// Shared types and encodings for the memory access stage.
package mem_stage_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE,
    WAIT_R
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response port.
interface mem_access_stage_if;
  import mem_stage_pkg::*;

  logic              DReq;
  logic              DWe;
  logic [WORD_W-1:0] DAddr;
  logic [WORD_W-1:0] DWData;
  logic [3:0]        DBe;
  logic              DGnt;
  logic              DRValid;
  logic [WORD_W-1:0] DRData;

  modport master (
    output DReq, DWe, DAddr, DWData, DBe,
    input  DGnt, DRValid, DRData
  );

  modport slave (
    input  DReq, DWe, DAddr, DWData, DBe,
    output DGnt, DRValid, DRData
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] sh;

  assign sh = rdata >> {addr, 3'b000};

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{24{sh[7]}}, sh[7:0]};
      (funct3 == F3_BU): data = {24'h0, sh[7:0]};
      (funct3 == F3_H):  data = {{16{sh[15]}}, sh[15:0]};
      (funct3 == F3_HU): data = {16'h0, sh[15:0]};
      default:           data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: data-memory access, load extension and M/W register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [word_width-1:0] PCPlus4M,
  mem_access_stage_if.master    dmem,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  MisalignW,
  output logic [1:0]            ResultSrcW,
  output logic [word_width-1:0] ALUResultW,
  output logic [word_width-1:0] ReadDataW,
  output logic [word_width-1:0] PCPlus4W,
  output logic [4:0]            RdW
);

  state_t            state;
  logic              is_load;
  logic              mem_op;
  logic              sz_b;
  logic              sz_h;
  logic              sz_w;
  logic              misalign;
  logic              req;
  logic              done;
  logic [3:0]        be_base;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] ext;

  assign is_load = (ResultSrcM == RES_MEM) && !MemWriteM;
  assign mem_op  = MemWriteM || is_load;
  assign sz_b    = Funct3M == F3_B || Funct3M == F3_BU;
  assign sz_h    = Funct3M == F3_H || Funct3M == F3_HU;
  assign sz_w    = !sz_b && !sz_h;

  assign misalign = mem_op &&
    ((sz_h && ALUResultM[0]) ||
     (sz_w && ALUResultM[1:0] != 2'b00));

  assign req  = reset && state == IDLE && mem_op && !misalign;
  assign done = state == WAIT_R && dmem.DRValid;

  always_comb begin
    be_base = 4'b1111;
    wdata   = WriteDataM;
    unique case (1'b1)
      sz_b: begin
        be_base = 4'b0001;
        wdata   = {4{WriteDataM[7:0]}};
      end
      sz_h: begin
        be_base = 4'b0011;
        wdata   = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_base = 4'b1111;
        wdata   = WriteDataM;
      end
    endcase
  end

  // Outputs are gated by reset so an abort clears them immediately.
  assign dmem.DReq   = req;
  assign dmem.DWe    = req && MemWriteM;
  assign dmem.DAddr  = reset ? {ALUResultM[WORD_W-1:2], 2'b00} : '0;
  assign dmem.DWData = reset ? wdata : '0;
  assign dmem.DBe    = (req && MemWriteM) ?
                       be_base << ALUResultM[1:0] : 4'b0000;

  assign StallM = reset &&
    ((req && (!dmem.DGnt || is_load)) ||
     (state == WAIT_R && !dmem.DRValid));

  load_align u_align (
    .rdata  (dmem.DRData),
    .addr   (ALUResultM[1:0]),
    .funct3 (Funct3M),
    .data   (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (req && dmem.DGnt && is_load) state <= WAIT_R;
        WAIT_R:
          if (dmem.DRValid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) ReadDataW <= ext;
      if (StallM) begin
        RegWriteW <= 1'b0;
        MisalignW <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM && !misalign;
        MisalignW  <= misalign;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
      end
    end
  end

endmodule
